pc_fetch: RTL
=============

# pc_fetch

Program-counter register and instruction-fetch sequencer for the single-issue core. Holds the architectural PC and drives it to the PC adder. Takes the adder's PC+4 result back as the sequential next-PC and fetches from instruction memory over a one-outstanding request/valid handshake. Hands fetched instructions to decode over a valid/ready handshake, with stall and branch/jump redirect support.

## Interface
- RESET_VECTOR, 32'h00000000: PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- pc  out  32  current PC register; feeds the PC adder input.
- pc_plus4  in  32  PC adder output (pc+4, modulo 2^32).
- stall  in  1  hazard stall; blocks PC advance.
- branch_taken  in  1  branch redirect request.
- branch_target  in  32  branch target address.
- jump  in  1  jump redirect request.
- jump_target  in  32  jump target address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_valid  in  1  fetch response valid.
- imem_rdata  in  32  fetched instruction.
- inst  out  32  instruction to decode.
- inst_valid  out  1  inst holds a valid instruction.
- inst_ready  in  1  decode accepts inst.
- misaligned  out  1  sticky flag: a redirect target had bits [1:0] != 0.

## Operation
- Registers:
  - pc
  - fetch_addr (address of the outstanding request)
  - inst
  - inst_valid
  - misaligned
  - state, one of IDLE, FETCH, HOLD, DISCARD
- Reset (rst low, asynchronous) forces:
  - pc=RESET_VECTOR, fetch_addr=RESET_VECTOR
  - state=IDLE
  - inst=0, inst_valid=0, misaligned=0
  - imem_req=0 combinationally
- Redirect = jump | branch_taken. Target priority: jump_target over branch_target. The loaded target has bits [1:0] forced to 0; nonzero bits set misaligned, which holds until reset.
- Next sequential PC is pc_plus4, used unmodified. Wrap 32'hFFFFFFFC -> 32'h00000000 is legal.
- imem_req=1 in FETCH and DISCARD. imem_addr=fetch_addr. Both stay stable until imem_valid is seen.
- IDLE: imem_valid is ignored. Next edge -> FETCH, with fetch_addr=pc.
- FETCH:
  - Redirect: pc<=target.
    - imem_valid same cycle: drop the data, fetch_addr<=target, stay FETCH.
    - Otherwise -> DISCARD.
  - Else if imem_valid: inst<=imem_rdata, inst_valid<=1, -> HOLD.
- HOLD:
  - Redirect: pc<=target, fetch_addr<=target, inst_valid<=0, -> FETCH. Redirect overrides stall and inst_ready.
  - Else if inst_ready & ~stall: pc<=pc_plus4, fetch_addr<=pc_plus4, inst_valid<=0, -> FETCH.
  - Else hold everything.
- DISCARD:
  - On imem_valid: drop the data, fetch_addr<=pc, -> FETCH.
  - A further redirect in DISCARD updates pc only.
- imem_valid arriving while imem_req=0 is ignored.

## Timing
- Reset release to first request: the first rising edge with rst high moves IDLE->FETCH; imem_req=1 from that cycle.
- Fetch to decode: imem_valid in cycle N gives inst_valid=1 from cycle N+1.
- Best-case throughput is one instruction per 2 cycles (FETCH, HOLD) with zero-wait memory and inst_ready=1.
- Redirect latency: target appears on pc and imem_addr the cycle after redirect is sampled. With a request outstanding, it waits until the old response is discarded.
- The stale instruction is never presented with inst_valid=1 after a redirect is sampled.
- Asserting rst mid-fetch clears state immediately. The late response from the aborted request is ignored in IDLE.

## Test plan
- Reset then free run, with RESET_VECTOR=0, zero-wait imem, inst_ready=1, and an external adder:
  - imem_addr sequence 0x0, 0x4, 0x8
  - inst_valid pulses every other cycle with the matching rdata
- Stall in HOLD at pc=0x8, held 3 cycles: inst_valid stays 1, pc stays 0x8, no new imem_req. After release, pc=0xC.
- Redirects:
  - branch_taken=1, branch_target=0x100 in HOLD: the next fetch is 0x100 and the held instruction is dropped.
  - jump=1 and branch_taken=1 together (jump_target=0x200, branch_target=0x300): pc=0x200.
- Redirect in FETCH with imem_valid delayed 2 cycles:
  - imem_addr holds the old address until valid
  - the response is discarded and the next imem_addr equals the target
- Misaligned jump_target=0x102: pc=0x100, misaligned=1, which stays set through later redirects until rst.
- Wrap and async reset:
  - pc=0xFFFFFFFC advances to 0x0.
  - rst pulsed low mid-FETCH: outputs reset immediately and the late imem_valid produces no inst_valid.

Source files
------------

// File: rtl/pc_fetch.sv
// PC register and one-outstanding instruction-fetch sequencer.
// Hands fetched words to decode over valid/ready with stall and redirect.
module pc_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] fetch_addr;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;
    logic        advance;
    logic        take_redir;

    assign redirect   = jump | branch_taken;
    assign target_raw = jump ? jump_target : branch_target;
    assign target     = {target_raw[31:2], 2'b00};
    assign advance    = inst_ready & ~stall;
    // Redirects only take effect once the sequencer has left IDLE.
    assign take_redir = redirect & (state != IDLE);
    assign imem_addr  = fetch_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                if (redirect) begin
                    state_nx = imem_valid ? FETCH : DISCARD;
                end else if (imem_valid) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (redirect || advance) begin
                    state_nx = FETCH;
                end
            end
            DISCARD: begin
                if (imem_valid) begin
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == FETCH) || (state == DISCARD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_VECTOR;
            fetch_addr <= RESET_VECTOR;
            inst       <= 32'h0;
            inst_valid <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            if (take_redir) begin
                pc <= target;
                if (target_raw[1:0] != 2'b00) begin
                    misaligned <= 1'b1;
                end
            end else if (state == HOLD && advance) begin
                pc <= pc_plus4;
            end

            unique case (state)
                IDLE: fetch_addr <= pc;
                FETCH: begin
                    if (redirect) begin
                        if (imem_valid) begin
                            fetch_addr <= target;
                        end
                    end else if (imem_valid) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_addr <= target;
                        inst_valid <= 1'b0;
                    end else if (advance) begin
                        fetch_addr <= pc_plus4;
                        inst_valid <= 1'b0;
                    end
                end
                DISCARD: begin
                    // A redirect landing with the stale response wins over pc.
                    if (imem_valid) begin
                        fetch_addr <= redirect ? target : pc;
                    end
                end
                default: fetch_addr <= fetch_addr;
            endcase
        end
    end

endmodule
